// File: rtl/nand_arbiter_if.sv
// Requester-side bundle for nand_arbiter: request/operand inputs and
// grant/completion/status outputs.
interface nand_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int CNTW  = 16
);
    logic                  en;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_bus;
    logic [NREQ*WIDTH-1:0] b_bus;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      y_out;
    logic                  busy;
    logic [CNTW-1:0]       op_count;

    modport master (
        output en, req, a_bus, b_bus,
        input  gnt, done, y_out, busy, op_count
    );

    modport slave (
        input  en, req, a_bus, b_bus,
        output gnt, done, y_out, busy, op_count
    );
endinterface

// File: rtl/nand_arbiter.sv
// Round-robin arbiter/sequencer sharing one external WIDTH-bit nand gate
// among NREQ requesters: capture operands, drive the gate, return the result.
module nand_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    nand_arbiter_if.slave    rq,
    output logic [WIDTH-1:0] nand_a,
    output logic [WIDTH-1:0] nand_b,
    input  logic [WIDTH-1:0] nand_y
);
    localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NR = NREQ;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   sel;
    logic            found;
    int unsigned     idx;

    // First set request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = (32'(ptr) + k) % NR;
            if (!found && rq.req[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            rq.gnt      <= '0;
            rq.done     <= '0;
            rq.y_out    <= '0;
            rq.busy     <= 1'b0;
            rq.op_count <= '0;
            nand_a      <= '0;
            nand_b      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rq.en && found) begin
                        owner   <= sel;
                        nand_a  <= rq.a_bus[sel*WIDTH +: WIDTH];
                        nand_b  <= rq.b_bus[sel*WIDTH +: WIDTH];
                        rq.gnt  <= {{(NREQ-1){1'b0}}, 1'b1} << sel;
                        rq.busy <= 1'b1;
                        state   <= EXEC;
                    end else begin
                        rq.gnt  <= '0;
                    end
                end
                EXEC: begin
                    rq.y_out    <= nand_y;
                    rq.done     <= {{(NREQ-1){1'b0}}, 1'b1} << owner;
                    rq.gnt      <= '0;
                    rq.op_count <= rq.op_count + 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    rq.done <= '0;
                    ptr     <= (owner == PW'(NREQ-1)) ? '0 : owner + 1'b1;
                    rq.busy <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
